// File: rtl/st_bus_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// st_bus_timing_gen_pkg
// Shared definitions for the ST-bus frame timing generator: lock FSM state
// encoding, the active level of the F0 frame pulse and the frame-length helper.
// ---------------------------------------------------------------------------
package st_bus_timing_gen_pkg;

  // Lock FSM states; encodings are fixed so status readouts stay stable.
  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_LOCK  = 2'd2
  } state_e;

  // F0 is an active-low pulse.
  localparam logic F0_ACTIVE = 1'b0;

  // c4 cycles in one 125 us frame.
  function automatic int calc_frame_len(input int slots, input int bits_per_slot,
                                        input int clk_per_bit);
    return slots * bits_per_slot * clk_per_bit;
  endfunction

endpackage

// File: rtl/st_bus_rate_div.sv
// ---------------------------------------------------------------------------
// st_bus_rate_div
// One output channel of the timing generator. Derives the bit-phase from the
// shared frame counter and produces registered tx/rx enables and bit clocks at
// full or half rate.
// Ports:
//   i_clk, i_rst   c4 clock, synchronous active-high reset
//   i_fcnt         current frame counter value
//   i_select       requested rate (0 = full, 1 = half)
//   i_wrap         high in the cycle before the frame counter becomes 0
//   i_run          generator is in CHECK or LOCK; outputs held 0 otherwise
//   o_clk_en_tx    1-cycle enable at the bit boundary
//   o_clk_en_rx    1-cycle enable at mid-bit
//   o_clk_tx       50% duty bit clock
//   o_clk_rx       inverse of o_clk_tx while running
// ---------------------------------------------------------------------------
module st_bus_rate_div #(
  parameter int CLK_PER_BIT = 2,
  parameter int FCNT_W      = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [FCNT_W-1:0] i_fcnt,
  input  logic              i_select,
  input  logic              i_wrap,
  input  logic              i_run,
  output logic              o_clk_en_tx,
  output logic              o_clk_en_rx,
  output logic              o_clk_tx,
  output logic              o_clk_rx
);

  localparam logic [FCNT_W-1:0] DIV_FULL = FCNT_W'(CLK_PER_BIT);
  localparam logic [FCNT_W-1:0] DIV_HALF = FCNT_W'(2 * CLK_PER_BIT);

  logic              r_sel;
  logic              r_clk_en_tx;
  logic              r_clk_en_rx;
  logic              r_clk_tx;
  logic              r_clk_rx;
  logic [FCNT_W-1:0] w_ph;
  logic [FCNT_W-1:0] w_div;
  logic [FCNT_W-1:0] w_half;

  // Bit phase for the latched rate; both divisors are constants so each
  // modulo is a fixed reduction rather than a general divider.
  always_comb begin
    if (r_sel) begin
      w_div = DIV_HALF;
      w_ph  = i_fcnt % DIV_HALF;
    end else begin
      w_div = DIV_FULL;
      w_ph  = i_fcnt % DIV_FULL;
    end
  end

  assign w_half = w_div >> 1;

  // Rate latch (only at the frame boundary, so a period is never cut short)
  // and registered channel outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel       <= 1'b0;
      r_clk_en_tx <= 1'b0;
      r_clk_en_rx <= 1'b0;
      r_clk_tx    <= 1'b0;
      r_clk_rx    <= 1'b0;
    end else begin
      if (i_wrap) begin
        r_sel <= i_select;
      end
      r_clk_en_tx <= i_run && (w_ph == (w_div - FCNT_W'(1)));
      r_clk_en_rx <= i_run && (w_ph == (w_half - FCNT_W'(1)));
      r_clk_tx    <= i_run && (w_ph < w_half);
      r_clk_rx    <= i_run && !(w_ph < w_half);
    end
  end

  assign o_clk_en_tx = r_clk_en_tx;
  assign o_clk_en_rx = r_clk_en_rx;
  assign o_clk_tx    = r_clk_tx;
  assign o_clk_rx    = r_clk_rx;

endmodule

// File: rtl/st_bus_timing_gen.sv
// ---------------------------------------------------------------------------
// st_bus_timing_gen
// ST-bus frame timing generator. Locks to the 8 kHz active-low F0 pulse,
// flywheels through missing/corrupt pulses and produces per-channel bit
// clocks/enables plus slot/bit indices and lock status.
// Ports:
//   i_c4          system clock (4.096 MHz)
//   i_rst         synchronous reset, active high
//   i_f0          frame pulse, active low, one cycle wide
//   i_select      per-channel rate select (0 full, 1 half)
//   o_clk_en_tx   per-channel tx enable at bit boundary
//   o_clk_en_rx   per-channel rx enable at mid-bit
//   o_clk_tx      per-channel bit clock
//   o_clk_rx      per-channel inverted bit clock
//   o_slot_idx    full-rate timeslot index
//   o_bit_idx     full-rate bit index within the slot
//   o_frame_start pulse in the cycle the frame counter is 0
//   o_locked      high while in LOCK
//   o_sync_err    pulse at the wrap of each bad frame while locked
// ---------------------------------------------------------------------------
module st_bus_timing_gen
  import st_bus_timing_gen_pkg::*;
#(
  parameter int CLK_PER_BIT   = 2,
  parameter int BITS_PER_SLOT = 8,
  parameter int SLOTS         = 32,
  parameter int NUM_CH        = 2,
  parameter int LOCK_FRAMES   = 2,
  parameter int LOSS_FRAMES   = 2
) (
  input  logic                             i_c4,
  input  logic                             i_rst,
  input  logic                             i_f0,
  input  logic [NUM_CH-1:0]                i_select,
  output logic [NUM_CH-1:0]                o_clk_en_tx,
  output logic [NUM_CH-1:0]                o_clk_en_rx,
  output logic [NUM_CH-1:0]                o_clk_tx,
  output logic [NUM_CH-1:0]                o_clk_rx,
  output logic [$clog2(SLOTS)-1:0]         o_slot_idx,
  output logic [$clog2(BITS_PER_SLOT)-1:0] o_bit_idx,
  output logic                             o_frame_start,
  output logic                             o_locked,
  output logic                             o_sync_err
);

  localparam int FRAME_LEN = calc_frame_len(SLOTS, BITS_PER_SLOT, CLK_PER_BIT);
  localparam int FCNT_W    = $clog2(FRAME_LEN);
  localparam int SLOT_W    = $clog2(SLOTS);
  localparam int BIT_W     = $clog2(BITS_PER_SLOT);
  localparam int CNT_W     = $clog2(LOCK_FRAMES + LOSS_FRAMES + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);

  logic              r_f0;
  logic [FCNT_W-1:0] r_fcnt;
  logic [FCNT_W-1:0] w_fcnt_nxt;
  logic [FCNT_W-1:0] w_bit_num;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_good_cnt;
  logic [CNT_W-1:0]  w_good_nxt;
  logic [CNT_W-1:0]  w_good_inc;
  logic [CNT_W-1:0]  r_bad_cnt;
  logic [CNT_W-1:0]  w_bad_nxt;
  logic [CNT_W-1:0]  w_bad_inc;
  logic              r_early;
  logic              w_early_nxt;
  logic              w_hit;
  logic              w_expected;
  logic              w_accept;
  logic              w_err;
  logic              w_run;
  logic              w_run_nxt;
  logic              w_wrap_nxt;
  logic              r_frame_start;
  logic              r_locked;
  logic              r_sync_err;
  logic [SLOT_W-1:0] r_slot;
  logic [BIT_W-1:0]  r_bit;

  assign w_hit      = (r_f0 == F0_ACTIVE);
  assign w_expected = (r_fcnt == FCNT_LAST);
  assign w_good_inc = r_good_cnt + CNT_W'(1);
  assign w_bad_inc  = r_bad_cnt + CNT_W'(1);

  // Lock FSM next-state: HUNT waits for any pulse, CHECK verifies spacing,
  // LOCK flywheels and counts bad frames. An early pulse in LOCK is only
  // remembered, so several in one frame still make a single bad frame.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_bad_nxt   = r_bad_cnt;
    w_early_nxt = r_early;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_HUNT: begin
        w_bad_nxt   = '0;
        w_early_nxt = 1'b0;
        if (w_hit) begin
          w_accept    = 1'b1;
          w_good_nxt  = CNT_W'(1);
          w_state_nxt = ST_CHECK;
        end else begin
          w_good_nxt = '0;
        end
      end
      ST_CHECK: begin
        if (w_hit) begin
          w_accept = 1'b1;
          if (w_expected && (w_good_inc >= CNT_W'(LOCK_FRAMES))) begin
            w_good_nxt  = '0;
            w_state_nxt = ST_LOCK;
          end else if (w_expected) begin
            w_good_nxt = w_good_inc;
          end else begin
            w_good_nxt = CNT_W'(1);
          end
        end else if (w_expected) begin
          w_good_nxt  = '0;
          w_state_nxt = ST_HUNT;
        end else begin
          w_good_nxt = r_good_cnt;
        end
      end
      ST_LOCK: begin
        if (w_expected) begin
          w_accept    = w_hit;
          w_early_nxt = 1'b0;
          if (!w_hit || r_early) begin
            w_err = 1'b1;
            if (w_bad_inc >= CNT_W'(LOSS_FRAMES)) begin
              w_bad_nxt   = '0;
              w_state_nxt = ST_HUNT;
            end else begin
              w_bad_nxt = w_bad_inc;
            end
          end else begin
            w_bad_nxt = '0;
          end
        end else if (w_hit) begin
          w_early_nxt = 1'b1;
        end else begin
          w_early_nxt = r_early;
        end
      end
      default: begin
        w_state_nxt = ST_HUNT;
        w_good_nxt  = '0;
        w_bad_nxt   = '0;
        w_early_nxt = 1'b0;
      end
    endcase
  end

  // Frame counter next value: reload on an accepted pulse, otherwise count and wrap.
  always_comb begin
    if (w_accept || w_expected) begin
      w_fcnt_nxt = '0;
    end else begin
      w_fcnt_nxt = r_fcnt + FCNT_W'(1);
    end
  end

  assign w_wrap_nxt = (w_fcnt_nxt == '0);
  assign w_run      = (r_state != ST_HUNT);
  assign w_run_nxt  = (w_state_nxt != ST_HUNT);
  assign w_bit_num  = w_fcnt_nxt / FCNT_W'(CLK_PER_BIT);

  // State, counters and the frame-aligned outputs; the frame-aligned outputs
  // are computed from next-state values so they line up with the counter.
  always_ff @(posedge i_c4) begin
    if (i_rst) begin
      r_f0          <= ~F0_ACTIVE;
      r_fcnt        <= '0;
      r_state       <= ST_HUNT;
      r_good_cnt    <= '0;
      r_bad_cnt     <= '0;
      r_early       <= 1'b0;
      r_frame_start <= 1'b0;
      r_locked      <= 1'b0;
      r_sync_err    <= 1'b0;
      r_slot        <= '0;
      r_bit         <= '0;
    end else begin
      r_f0          <= i_f0;
      r_fcnt        <= w_fcnt_nxt;
      r_state       <= w_state_nxt;
      r_good_cnt    <= w_good_nxt;
      r_bad_cnt     <= w_bad_nxt;
      r_early       <= w_early_nxt;
      r_frame_start <= w_run_nxt && w_wrap_nxt;
      r_locked      <= (w_state_nxt == ST_LOCK);
      r_sync_err    <= w_err;
      r_slot        <= w_run_nxt ? SLOT_W'(w_bit_num / FCNT_W'(BITS_PER_SLOT)) : '0;
      r_bit         <= w_run_nxt ? BIT_W'(w_bit_num % FCNT_W'(BITS_PER_SLOT)) : '0;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    st_bus_rate_div #(
      .CLK_PER_BIT(CLK_PER_BIT),
      .FCNT_W     (FCNT_W)
    ) u_rate_div (
      .i_clk      (i_c4),
      .i_rst      (i_rst),
      .i_fcnt     (r_fcnt),
      .i_select   (i_select[gi]),
      .i_wrap     (w_wrap_nxt),
      .i_run      (w_run),
      .o_clk_en_tx(o_clk_en_tx[gi]),
      .o_clk_en_rx(o_clk_en_rx[gi]),
      .o_clk_tx   (o_clk_tx[gi]),
      .o_clk_rx   (o_clk_rx[gi])
    );
  end

  assign o_slot_idx    = r_slot;
  assign o_bit_idx     = r_bit;
  assign o_frame_start = r_frame_start;
  assign o_locked      = r_locked;
  assign o_sync_err    = r_sync_err;

endmodule
